// File: rtl/wb_stage_if.sv
// MEM-to-writeback handshake bundle: one retiring instruction per valid/ready transfer.
// The MEM stage drives the master side; the writeback stage owns mem_ready.
interface wb_stage_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
);
  logic              mem_valid;
  logic              mem_ready;
  logic [ADDR_W-1:0] mem_rd;
  logic              mem_reg_we;
  logic [1:0]        mem_wb_sel;
  logic [XLEN-1:0]   mem_alu_res;
  logic [XLEN-1:0]   mem_pc;
  logic [2:0]        mem_funct3;

  modport master (
    output mem_valid, mem_rd, mem_reg_we, mem_wb_sel, mem_alu_res, mem_pc, mem_funct3,
    input  mem_ready
  );

  modport slave (
    input  mem_valid, mem_rd, mem_reg_we, mem_wb_sel, mem_alu_res, mem_pc, mem_funct3,
    output mem_ready
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: retires instructions from MEM, waits for load data when needed,
// aligns/extends it and issues one registered register-file write pulse per instruction.
module wb_stage #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  wb_stage_if.slave         mem,
  input  logic              dmem_rvalid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [XLEN-1:0]   write_value,
  output logic              load_pending,
  output logic [ADDR_W-1:0] load_rd,
  output logic              exc_pulse,
  output logic [63:0]       instret
);

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] ld_rd;
  logic [1:0]        ld_off;
  logic [2:0]        ld_funct3;
  logic              ld_we;
  logic              accept;
  logic              done;
  logic              do_write;
  logic              do_exc;
  logic [ADDR_W-1:0] addr_next;
  logic [XLEN-1:0]   value_next;
  logic [7:0]        ld_byte;
  logic [15:0]       ld_half;
  logic [XLEN-1:0]   ld_value;
  logic              ld_bad;

  // Ready is held low while reset is asserted so every output reads 0 during reset.
  assign mem.mem_ready = reset && (state == IDLE);
  assign accept        = mem.mem_valid && mem.mem_ready;
  assign load_pending  = (state == WAIT_LOAD);
  assign load_rd       = load_pending ? ld_rd : '0;

  always_comb begin
    ld_byte  = dmem_rdata[7:0];
    ld_half  = ld_off[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    ld_value = dmem_rdata;
    ld_bad   = 1'b0;
    case (ld_off)
      2'd0:    ld_byte = dmem_rdata[7:0];
      2'd1:    ld_byte = dmem_rdata[15:8];
      2'd2:    ld_byte = dmem_rdata[23:16];
      default: ld_byte = dmem_rdata[31:24];
    endcase
    case (ld_funct3)
      3'b000:  ld_value = {{(XLEN-8){ld_byte[7]}}, ld_byte};
      3'b100:  ld_value = {{(XLEN-8){1'b0}}, ld_byte};
      3'b001: begin
        ld_value = {{(XLEN-16){ld_half[15]}}, ld_half};
        ld_bad   = ld_off[0];
      end
      3'b101: begin
        ld_value = {{(XLEN-16){1'b0}}, ld_half};
        ld_bad   = ld_off[0];
      end
      3'b010: begin
        ld_value = dmem_rdata;
        ld_bad   = (ld_off != 2'd0);
      end
      default: ld_bad = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Non-loads complete on the accept edge; loads complete on the rvalid edge.
  always_comb begin
    state_next = state;
    done       = 1'b0;
    do_write   = 1'b0;
    do_exc     = 1'b0;
    addr_next  = write_addr;
    value_next = write_value;
    case (state)
      IDLE: begin
        if (accept) begin
          if (mem.mem_wb_sel == 2'b01) begin
            state_next = WAIT_LOAD;
          end else begin
            done = 1'b1;
            if (mem.mem_wb_sel == 2'b11) begin
              do_exc = 1'b1;
            end else begin
              do_write   = mem.mem_reg_we && (mem.mem_rd != '0);
              addr_next  = mem.mem_rd;
              value_next = (mem.mem_wb_sel == 2'b10) ? mem.mem_pc + XLEN'(4) : mem.mem_alu_res;
            end
          end
        end
      end
      WAIT_LOAD: begin
        if (dmem_rvalid) begin
          state_next = IDLE;
          done       = 1'b1;
          if (ld_bad) begin
            do_exc = 1'b1;
          end else begin
            do_write   = ld_we && (ld_rd != '0);
            addr_next  = ld_rd;
            value_next = ld_value;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Write address/value only move on a real write so the forwarding source stays stable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      write_en    <= 1'b0;
      write_addr  <= '0;
      write_value <= '0;
      exc_pulse   <= 1'b0;
      instret     <= 64'd0;
      ld_rd       <= '0;
      ld_off      <= 2'd0;
      ld_funct3   <= 3'd0;
      ld_we       <= 1'b0;
    end else begin
      write_en  <= do_write;
      exc_pulse <= do_exc;
      if (do_write) begin
        write_addr  <= addr_next;
        write_value <= value_next;
      end
      if (done) instret <= instret + 64'd1;
      if (accept && (mem.mem_wb_sel == 2'b01)) begin
        ld_rd     <= mem.mem_rd;
        ld_off    <= mem.mem_alu_res[1:0];
        ld_funct3 <= mem.mem_funct3;
        ld_we     <= mem.mem_reg_we;
      end
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, randomized instructions against an
// arithmetic reference model, and hand sequences for throughput, idle rvalid and reset.
module tb_wb_stage;
  localparam int XLEN   = 32;
  localparam int ADDR_W = 5;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              dmem_rvalid = 1'b0;
  logic [XLEN-1:0]   dmem_rdata = '0;
  logic              write_en;
  logic [ADDR_W-1:0] write_addr;
  logic [XLEN-1:0]   write_value;
  logic              load_pending;
  logic [ADDR_W-1:0] load_rd;
  logic              exc_pulse;
  logic [63:0]       instret;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] m_instret = 64'd0;
  logic [4:0]  m_addr    = 5'd0;
  logic [31:0] m_value   = 32'd0;

  always #5 clk = ~clk;

  wb_stage_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) bus ();

  wb_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .mem         (bus),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata),
    .write_en    (write_en),
    .write_addr  (write_addr),
    .write_value (write_value),
    .load_pending(load_pending),
    .load_rd     (load_rd),
    .exc_pulse   (exc_pulse),
    .instret     (instret)
  );

  typedef struct {
    logic [1:0]  sel;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [31:0] rdata;
    int          delay;
    logic        exp_en;
    logic        exp_exc;
    logic [31:0] exp_value;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input logic [1:0] sel, input logic [2:0] f3, input logic [4:0] rd,
                              input logic we, input logic [31:0] alu, input logic [31:0] pc,
                              input logic [31:0] rdata, input int delay, input logic en,
                              input logic exc, input logic [31:0] value);
    vec_t v;
    v.sel = sel; v.f3 = f3; v.rd = rd; v.we = we; v.alu = alu; v.pc = pc;
    v.rdata = rdata; v.delay = delay; v.exp_en = en; v.exp_exc = exc; v.exp_value = value;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decode the load/writeback rules with plain integer arithmetic.
  function automatic void ref_model(input vec_t v, output logic en, output logic exc,
                                    output logic [31:0] value);
    int unsigned a, b, h, rd_word;
    rd_word = v.rdata;
    a = v.alu % 4;
    b = (rd_word >> (8 * a)) % 256;
    h = (rd_word >> (16 * (a / 2))) % 65536;
    exc = 1'b0;
    value = 32'd0;
    case (v.sel)
      2'b00: value = v.alu;
      2'b10: value = v.pc + 32'd4;
      2'b11: exc = 1'b1;
      default: begin
        case (v.f3)
          3'd0: value = (b >= 128) ? b - 256 : b;
          3'd4: value = b;
          3'd1: if (a % 2 != 0) exc = 1'b1; else value = (h >= 32768) ? h - 65536 : h;
          3'd5: if (a % 2 != 0) exc = 1'b1; else value = h;
          3'd2: if (a != 0) exc = 1'b1; else value = rd_word;
          default: exc = 1'b1;
        endcase
      end
    endcase
    en = !exc && v.we && (v.rd != 5'd0);
  endfunction

  // Entered at a negedge or just after a posedge; returns at the negedge after completion.
  task automatic apply_stimulus(input vec_t v);
    check("ready_before_accept", 64'(bus.mem_ready), 64'd1);
    bus.mem_valid   = 1'b1;
    bus.mem_wb_sel  = v.sel;
    bus.mem_funct3  = v.f3;
    bus.mem_rd      = v.rd;
    bus.mem_reg_we  = v.we;
    bus.mem_alu_res = v.alu;
    bus.mem_pc      = v.pc;
    @(posedge clk); #1;
    bus.mem_valid   = 1'b0;
    if (v.sel == 2'b01) begin
      for (int i = 0; i < v.delay; i++) begin
        dmem_rdata = $urandom;
        @(negedge clk);
        check("ready_in_wait", 64'(bus.mem_ready), 64'd0);
        check("pending_in_wait", 64'(load_pending), 64'd1);
        check("load_rd_in_wait", 64'(load_rd), 64'(v.rd));
        check("write_en_in_wait", 64'(write_en), 64'd0);
        @(posedge clk); #1;
      end
      dmem_rvalid = 1'b1;
      dmem_rdata  = v.rdata;
      @(posedge clk); #1;
      dmem_rvalid = 1'b0;
      dmem_rdata  = $urandom;
    end
    @(negedge clk);
  endtask

  task automatic check_output(input logic en, input logic exc, input logic [31:0] value);
    m_instret = m_instret + 64'd1;
    if (en) begin
      m_addr  = bus.mem_rd;
      m_value = value;
    end
    check("write_en", 64'(write_en), 64'(en));
    check("exc_pulse", 64'(exc_pulse), 64'(exc));
    check("write_addr", 64'(write_addr), 64'(m_addr));
    check("write_value", 64'(write_value), 64'(m_value));
    check("instret", instret, m_instret);
    check("pending_after", 64'(load_pending), 64'd0);
    check("load_rd_after", 64'(load_rd), 64'd0);
    check("ready_after", 64'(bus.mem_ready), 64'd1);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        v;
    logic        e_en, e_exc;
    logic [31:0] e_val;

    bus.mem_valid = 1'b0; bus.mem_wb_sel = 2'b00; bus.mem_funct3 = 3'd0; bus.mem_rd = '0;
    bus.mem_reg_we = 1'b0; bus.mem_alu_res = '0; bus.mem_pc = '0;

    vecs[0]  = mk(2'b00, 3'd0,  5'd5, 1'b1, 32'h0000_1234, 32'h0,         32'h0,         0, 1'b1, 1'b0, 32'h0000_1234);
    vecs[1]  = mk(2'b01, 3'd0,  5'd7, 1'b1, 32'h0000_1003, 32'h0,         32'h80FF_FFFF, 3, 1'b1, 1'b0, 32'hFFFF_FF80);
    vecs[2]  = mk(2'b01, 3'd4,  5'd8, 1'b1, 32'h0000_1003, 32'h0,         32'h80FF_FFFF, 3, 1'b1, 1'b0, 32'h0000_0080);
    vecs[3]  = mk(2'b01, 3'd1,  5'd9, 1'b1, 32'h0000_2001, 32'h0,         32'h1234_5678, 1, 1'b0, 1'b1, 32'h0);
    vecs[4]  = mk(2'b10, 3'd0,  5'd1, 1'b1, 32'h0,         32'h0000_0100, 32'h0,         0, 1'b1, 1'b0, 32'h0000_0104);
    vecs[5]  = mk(2'b10, 3'd0,  5'd0, 1'b1, 32'h0,         32'h0000_0100, 32'h0,         0, 1'b0, 1'b0, 32'h0);
    vecs[6]  = mk(2'b01, 3'd2, 5'd10, 1'b1, 32'h0000_4000, 32'h0,         32'hDEAD_BEEF, 0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    vecs[7]  = mk(2'b01, 3'd5, 5'd11, 1'b1, 32'h0000_4002, 32'h0,         32'h8001_1234, 1, 1'b1, 1'b0, 32'h0000_8001);
    vecs[8]  = mk(2'b01, 3'd1, 5'd12, 1'b1, 32'h0000_4002, 32'h0,         32'h8001_1234, 2, 1'b1, 1'b0, 32'hFFFF_8001);
    vecs[9]  = mk(2'b01, 3'd2, 5'd13, 1'b1, 32'h0000_4002, 32'h0,         32'h8001_1234, 0, 1'b0, 1'b1, 32'h0);
    vecs[10] = mk(2'b01, 3'd3, 5'd14, 1'b1, 32'h0000_4000, 32'h0,         32'h1111_1111, 1, 1'b0, 1'b1, 32'h0);
    vecs[11] = mk(2'b11, 3'd0, 5'd15, 1'b1, 32'h0000_5555, 32'h0,         32'h0,         0, 1'b0, 1'b1, 32'h0);
    vecs[12] = mk(2'b00, 3'd0,  5'd3, 1'b0, 32'h0000_7777, 32'h0,         32'h0,         0, 1'b0, 1'b0, 32'h0);
    vecs[13] = mk(2'b10, 3'd0,  5'd2, 1'b1, 32'h0,         32'hFFFF_FFFC, 32'h0,         0, 1'b1, 1'b0, 32'h0000_0000);
    vecs[14] = mk(2'b01, 3'd0, 5'd16, 1'b1, 32'h0000_6001, 32'h0,         32'h0000_7F00, 2, 1'b1, 1'b0, 32'h0000_007F);
    vecs[15] = mk(2'b01, 3'd2, 5'd17, 1'b0, 32'h0000_6000, 32'h0,         32'hCAFE_F00D, 1, 1'b0, 1'b0, 32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_write_en", 64'(write_en), 64'd0);
    check("reset_write_value", 64'(write_value), 64'd0);
    check("reset_write_addr", 64'(write_addr), 64'd0);
    check("reset_instret", instret, 64'd0);
    check("reset_exc", 64'(exc_pulse), 64'd0);
    check("reset_pending", 64'(load_pending), 64'd0);
    check("reset_ready", 64'(bus.mem_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    check("ready_after_reset", 64'(bus.mem_ready), 64'd1);

    $display("[TB] directed vector table");
    for (int i = 0; i < 16; i++) begin
      apply_stimulus(vecs[i]);
      check_output(vecs[i].exp_en, vecs[i].exp_exc, vecs[i].exp_value);
    end

    $display("[TB] idle cycle with stray rvalid");
    @(posedge clk); #1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hAAAA_5555;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    check("idle_write_en", 64'(write_en), 64'd0);
    check("idle_exc", 64'(exc_pulse), 64'd0);
    check("idle_instret", instret, m_instret);
    check("idle_value_held", 64'(write_value), 64'(m_value));
    check("idle_pending", 64'(load_pending), 64'd0);

    $display("[TB] back-to-back ALU ops");
    bus.mem_valid = 1'b1; bus.mem_wb_sel = 2'b00; bus.mem_reg_we = 1'b1;
    bus.mem_rd = 5'd20; bus.mem_alu_res = 32'h0000_0A00;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (i < 3) begin
        bus.mem_rd      = 5'(21 + i);
        bus.mem_alu_res = 32'h0000_0A00 + 32'(i + 1);
      end else begin
        bus.mem_valid = 1'b0;
      end
      @(negedge clk);
      m_instret = m_instret + 64'd1;
      m_addr    = 5'(20 + i);
      m_value   = 32'h0000_0A00 + 32'(i);
      check("b2b_write_en", 64'(write_en), 64'd1);
      check("b2b_write_addr", 64'(write_addr), 64'(m_addr));
      check("b2b_write_value", 64'(write_value), 64'(m_value));
      check("b2b_instret", instret, m_instret);
      check("b2b_ready", 64'(bus.mem_ready), 64'd1);
    end
    @(negedge clk);
    check("b2b_pulse_ends", 64'(write_en), 64'd0);

    $display("[TB] randomized instructions against reference model");
    for (int i = 0; i < 40; i++) begin
      v.sel   = 2'($urandom_range(0, 3));
      v.f3    = 3'($urandom_range(0, 7));
      v.rd    = 5'($urandom);
      v.we    = 1'($urandom);
      v.alu   = $urandom;
      if ($urandom_range(0, 1) == 1) v.alu[1:0] = 2'b00;
      v.pc    = $urandom;
      v.rdata = $urandom;
      v.delay = $urandom_range(0, 3);
      ref_model(v, e_en, e_exc, e_val);
      apply_stimulus(v);
      check_output(e_en, e_exc, e_val);
    end

    $display("[TB] reset during pending load");
    bus.mem_valid = 1'b1; bus.mem_wb_sel = 2'b01; bus.mem_funct3 = 3'd0;
    bus.mem_rd = 5'd9; bus.mem_reg_we = 1'b1; bus.mem_alu_res = 32'h0000_0100;
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_pending", 64'(load_pending), 64'd1);
    check("rst_pre_load_rd", 64'(load_rd), 64'd9);
    #1;
    reset = 1'b0;
    #1;
    m_instret = 64'd0; m_addr = 5'd0; m_value = 32'd0;
    check("rst_pending", 64'(load_pending), 64'd0);
    check("rst_load_rd", 64'(load_rd), 64'd0);
    check("rst_instret", instret, 64'd0);
    check("rst_write_value", 64'(write_value), 64'd0);
    check("rst_write_en", 64'(write_en), 64'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h1234_5678;
    @(posedge clk); #1;
    dmem_rvalid = 1'b0;
    @(negedge clk);
    check("late_rvalid_write_en", 64'(write_en), 64'd0);
    check("late_rvalid_pending", 64'(load_pending), 64'd0);
    check("late_rvalid_instret", instret, 64'd0);
    check("late_rvalid_ready", 64'(bus.mem_ready), 64'd1);
    apply_stimulus(vecs[0]);
    check_output(vecs[0].exp_en, vecs[0].exp_exc, vecs[0].exp_value);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
